// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped, read-only instruction cache. Hits answer in one
//               cycle from line storage; misses refill a whole line word by
//               word from the memory controller and then answer as a hit.
// Revision    : 1.0 - initial release
// ============================================================================
module icache #(
    parameter int INDEX_WIDTH = 4,
    parameter int LINE_WIDTH  = 2,
    parameter int TAG_WIDTH   = 32 - INDEX_WIDTH - LINE_WIDTH - 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        icache_query_en,
    input  logic [31:0] icache_query_pc,
    output logic        icache_data_en,
    output logic [31:0] icache_data,
    output logic        mem_query_en,
    output logic [31:0] mem_query_addr,
    input  logic        mem_data_en,
    input  logic [31:0] mem_data
);

    localparam int LINES   = 1 << INDEX_WIDTH;
    localparam int WORDS   = 1 << LINE_WIDTH;
    localparam int IDX_LSB = LINE_WIDTH + 2;
    localparam int TAG_LSB = INDEX_WIDTH + LINE_WIDTH + 2;
    localparam logic [LINE_WIDTH-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RESPOND   = 2'd1,
        S_MISS_REQ  = 2'd2,
        S_MISS_WAIT = 2'd3
    } state_t;

    // Line storage
    logic [LINES-1:0]     valid_q;
    logic [TAG_WIDTH-1:0] line_tag_q  [LINES];
    logic [31:0]          line_data_q [LINES*WORDS];

    // Control registers
    state_t                state_q,    state_d;
    logic [31:0]           req_pc_q,   req_pc_d;
    logic [LINE_WIDTH-1:0] cnt_q,      cnt_d;
    logic                  data_en_q,  data_en_d;
    logic [31:0]           rdata_q,    rdata_d;
    logic                  mem_en_q,   mem_en_d;
    logic [31:0]           mem_addr_q, mem_addr_d;

    // Storage update strobes from the FSM
    logic w_fill_wr;
    logic w_fill_last;
    logic w_line_inval;

    // Address fields of the incoming query and of the latched request
    logic [LINE_WIDTH-1:0]  w_q_off;
    logic [INDEX_WIDTH-1:0] w_q_idx;
    logic [TAG_WIDTH-1:0]   w_q_tag;
    logic [INDEX_WIDTH-1:0] w_r_idx;
    logic [TAG_WIDTH-1:0]   w_r_tag;
    logic                   w_hit;
    logic                   w_unused;

    assign w_q_off  = icache_query_pc[IDX_LSB-1:2];
    assign w_q_idx  = icache_query_pc[TAG_LSB-1:IDX_LSB];
    assign w_q_tag  = icache_query_pc[31:TAG_LSB];
    assign w_r_idx  = req_pc_q[TAG_LSB-1:IDX_LSB];
    assign w_r_tag  = req_pc_q[31:TAG_LSB];
    assign w_hit    = valid_q[w_q_idx] && (line_tag_q[w_q_idx] == w_q_tag);
    assign w_unused = ^{icache_query_pc[1:0], req_pc_q[IDX_LSB-1:0]};

    assign icache_data_en = data_en_q;
    assign icache_data    = rdata_q;
    assign mem_query_en   = mem_en_q;
    assign mem_query_addr = mem_addr_q;

    // Next-state and output decode for the lookup/refill sequencer
    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        cnt_d        = cnt_q;
        data_en_d    = data_en_q;
        rdata_d      = rdata_q;
        mem_en_d     = mem_en_q;
        mem_addr_d   = mem_addr_q;
        w_fill_wr    = 1'b0;
        w_fill_last  = 1'b0;
        w_line_inval = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (icache_query_en) begin
                    req_pc_d = icache_query_pc;
                    if (w_hit) begin
                        rdata_d   = line_data_q[{w_q_idx, w_q_off}];
                        data_en_d = 1'b1;
                        state_d   = S_RESPOND;
                    end else begin
                        // The victim line goes invalid now so an aborted
                        // refill can never leave a half-written line valid.
                        w_line_inval = 1'b1;
                        cnt_d        = '0;
                        state_d      = S_MISS_REQ;
                    end
                end
            end
            S_RESPOND: begin
                // Fetcher drops query_en on this edge; ignoring it here
                // guarantees a single pulse per query.
                data_en_d = 1'b0;
                state_d   = S_IDLE;
            end
            S_MISS_REQ: begin
                mem_en_d   = 1'b1;
                mem_addr_d = {req_pc_q[31:IDX_LSB], cnt_q, 2'b00};
                state_d    = S_MISS_WAIT;
            end
            S_MISS_WAIT: begin
                if (mem_data_en) begin
                    w_fill_wr = 1'b1;
                    mem_en_d  = 1'b0;
                    if (cnt_q == LAST_WORD) begin
                        w_fill_last = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + LINE_WIDTH'(1);
                        state_d = S_MISS_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control register update; rdy_in low freezes everything
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            req_pc_q   <= '0;
            cnt_q      <= '0;
            data_en_q  <= 1'b0;
            rdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            cnt_q      <= cnt_d;
            data_en_q  <= data_en_d;
            rdata_q    <= rdata_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Valid bits: cleared on miss start, set once the last refill word lands
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (rdy_in) begin
            if (w_line_inval) begin
                valid_q[w_q_idx] <= 1'b0;
            end
            if (w_fill_last) begin
                valid_q[w_r_idx] <= 1'b1;
            end
        end
    end

    // Tag and word storage written by the refill
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            if (w_fill_wr) begin
                line_data_q[{w_r_idx, cnt_q}] <= mem_data;
            end
            if (w_fill_last) begin
                line_tag_q[w_r_idx] <= w_r_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_icache
// Description : Self-checking bench for icache with a latency-2 memory model
//               and a queue of expected fetch responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        icache_query_en;
    logic [31:0] icache_query_pc;
    logic        icache_data_en;
    logic [31:0] icache_data;
    logic        mem_query_en;
    logic [31:0] mem_query_addr;
    logic        mem_data_en;
    logic [31:0] mem_data;

    int          tests;
    int          fails;
    int          pulses;
    bit          mem_hold;
    logic [31:0] exp_q    [$];
    logic [31:0] obs_addr [$];
    logic        gap_q    [$];

    icache dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .icache_query_en (icache_query_en),
        .icache_query_pc (icache_query_pc),
        .icache_data_en  (icache_data_en),
        .icache_data     (icache_data),
        .mem_query_en    (mem_query_en),
        .mem_query_addr  (mem_query_addr),
        .mem_data_en     (mem_data_en),
        .mem_data        (mem_data)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Memory contents: word at 0x10 is 0xA0, 0x14 is 0xA1, 0x110 is 0xE0 ...
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h9C + (a >> 2);
    endfunction

    // Memory controller model: answers each request two cycles later
    initial begin : mem_model
        logic        serving;
        int          countdown;
        logic [31:0] addr;
        serving     = 1'b0;
        countdown   = 0;
        addr        = '0;
        mem_data_en = 1'b0;
        mem_data    = '0;
        forever begin
            @(posedge clk_in); #1;
            if (rst_in) begin
                serving     = 1'b0;
                mem_data_en = 1'b0;
            end else if (mem_data_en) begin
                mem_data_en = 1'b0;
                serving     = 1'b0;
                gap_q.push_back(mem_query_en);
            end else if (serving) begin
                if (!mem_hold) begin
                    if (countdown <= 1) begin
                        mem_data_en = 1'b1;
                        mem_data    = mem_word(addr);
                    end else begin
                        countdown--;
                    end
                end
            end else if (mem_query_en) begin
                serving   = 1'b1;
                countdown = 2;
                addr      = mem_query_addr;
                obs_addr.push_back(mem_query_addr);
            end
        end
    end

    // Count fetch response pulses
    initial begin : pulse_mon
        pulses = 0;
        forever begin
            @(posedge clk_in); #1;
            if (icache_data_en) pulses++;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in); #1;
    endtask

    task automatic start_query(input logic [31:0] pc, input logic [31:0] exp);
        exp_q.push_back(exp);
        icache_query_pc = pc;
        icache_query_en = 1'b1;
    endtask

    // Waits for the response, pops the scoreboard and checks data and pulse width
    task automatic wait_resp(input string name, output int lat);
        bit          got;
        logic [31:0] exp;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            lat++;
            if (icache_data_en) got = 1'b1;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s_timeout: no data_en in 400 cycles, required one", name);
            icache_query_en = 1'b0;
        end else begin
            tests++;
            if (icache_data !== exp) begin
                fails++;
                $display("FAIL %s_data: got %h, required %h", name, icache_data, exp);
            end
            tick();
            tests++;
            if (icache_data_en !== 1'b0) begin
                fails++;
                $display("FAIL %s_pulse_width: data_en %b one cycle later, required 0",
                         name, icache_data_en);
            end
            icache_query_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_in          = 1'b1;
        rdy_in          = 1'b1;
        icache_query_en = 1'b0;
        icache_query_pc = '0;
        mem_hold        = 1'b0;
        tick(); tick(); tick();
        tests++;
        if (icache_data_en !== 1'b0) begin
            fails++; $display("FAIL reset_data_en: got %b, required 0", icache_data_en);
        end
        tests++;
        if (icache_data !== 32'h0) begin
            fails++; $display("FAIL reset_data: got %h, required 0", icache_data);
        end
        tests++;
        if (mem_query_en !== 1'b0) begin
            fails++; $display("FAIL reset_mem_en: got %b, required 0", mem_query_en);
        end
        tests++;
        if (mem_query_addr !== 32'h0) begin
            fails++; $display("FAIL reset_mem_addr: got %h, required 0", mem_query_addr);
        end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_cold_miss();
        int lat;
        obs_addr.delete();
        gap_q.delete();
        start_query(32'h0000_0010, 32'h0000_00A0);
        wait_resp("cold_miss", lat);
        tests++;
        if (obs_addr.size() != 4) begin
            fails++; $display("FAIL cold_req_count: got %0d, required 4", obs_addr.size());
        end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            tests++;
            if (obs_addr[i] !== 32'h10 + 32'(4 * i)) begin
                fails++;
                $display("FAIL cold_addr%0d: got %h, required %h", i, obs_addr[i],
                         32'h10 + 32'(4 * i));
            end
        end
        for (int i = 0; i < gap_q.size(); i++) begin
            tests++;
            if (gap_q[i] !== 1'b0) begin
                fails++; $display("FAIL cold_gap%0d: mem_query_en %b, required 0", i, gap_q[i]);
            end
        end
    endtask

    task automatic test_hit();
        int lat;
        int n0;
        n0 = obs_addr.size();
        start_query(32'h0000_0018, 32'h0000_00A2);
        wait_resp("hit", lat);
        tests++;
        if (lat != 1) begin
            fails++; $display("FAIL hit_latency: got %0d cycles, required 1", lat);
        end
        tests++;
        if (obs_addr.size() != n0) begin
            fails++; $display("FAIL hit_mem_req: got %0d requests, required %0d",
                              obs_addr.size(), n0);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int p0;
        p0 = pulses;
        start_query(32'h0000_0014, 32'h0000_00A1);
        wait_resp("b2b", lat);
        tests++;
        if (lat != 1) begin
            fails++; $display("FAIL b2b_latency: got %0d cycles, required 1", lat);
        end
        tick(); tick();
        tests++;
        if (pulses != p0 + 1) begin
            fails++; $display("FAIL b2b_pulses: got %0d, required %0d", pulses - p0, 1);
        end
    endtask

    task automatic test_conflict();
        int lat;
        obs_addr.delete();
        start_query(32'h0000_0110, 32'h0000_00E0);
        wait_resp("conflict", lat);
        tests++;
        if (obs_addr.size() != 4) begin
            fails++; $display("FAIL conflict_req_count: got %0d, required 4", obs_addr.size());
        end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            tests++;
            if (obs_addr[i] !== 32'h110 + 32'(4 * i)) begin
                fails++;
                $display("FAIL conflict_addr%0d: got %h, required %h", i, obs_addr[i],
                         32'h110 + 32'(4 * i));
            end
        end
        obs_addr.delete();
        start_query(32'h0000_0010, 32'h0000_00A0);
        wait_resp("evicted", lat);
        tests++;
        if (obs_addr.size() != 4 || obs_addr[0] !== 32'h10) begin
            fails++;
            $display("FAIL evicted_refill: got %0d requests, required 4 from 0x10",
                     obs_addr.size());
        end
    endtask

    task automatic test_reset_mid_refill();
        int lat;
        bit seen;
        obs_addr.delete();
        icache_query_pc = 32'h0000_0020;
        icache_query_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (obs_addr.size() >= 2) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++; $display("FAIL midrst_second_req: got %0d requests, required 2",
                              obs_addr.size());
        end
        rst_in          = 1'b1;
        icache_query_en = 1'b0;
        tick();
        tests++;
        if (mem_query_en !== 1'b0) begin
            fails++; $display("FAIL midrst_mem_en: got %b, required 0", mem_query_en);
        end
        tests++;
        if (icache_data_en !== 1'b0) begin
            fails++; $display("FAIL midrst_data_en: got %b, required 0", icache_data_en);
        end
        tick();
        rst_in = 1'b0;
        tick();
        obs_addr.delete();
        start_query(32'h0000_0010, 32'h0000_00A0);
        wait_resp("midrst_requery", lat);
        tests++;
        if (obs_addr.size() != 4) begin
            fails++; $display("FAIL midrst_refill_count: got %0d, required 4", obs_addr.size());
        end
        obs_addr.delete();
        start_query(32'h0000_0024, 32'h0000_00A5);
        wait_resp("aborted_line", lat);
        tests++;
        if (obs_addr.size() != 4) begin
            fails++; $display("FAIL aborted_line_refill: got %0d, required 4", obs_addr.size());
        end
    endtask

    task automatic test_rdy_stall();
        int lat;
        bit seen;
        obs_addr.delete();
        start_query(32'h0000_0030, 32'h0000_00A8);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (obs_addr.size() >= 1) seen = 1'b1;
        end
        mem_hold = 1'b1;
        rdy_in   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (mem_query_en !== 1'b1 || mem_query_addr !== 32'h30) begin
                fails++;
                $display("FAIL stall_hold%0d: en %b addr %h, required 1 and 00000030",
                         i, mem_query_en, mem_query_addr);
            end
        end
        rdy_in   = 1'b1;
        mem_hold = 1'b0;
        wait_resp("stall", lat);
        tests++;
        if (obs_addr.size() != 4) begin
            fails++; $display("FAIL stall_req_count: got %0d, required 4", obs_addr.size());
        end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            tests++;
            if (obs_addr[i] !== 32'h30 + 32'(4 * i)) begin
                fails++;
                $display("FAIL stall_addr%0d: got %h, required %h", i, obs_addr[i],
                         32'h30 + 32'(4 * i));
            end
        end
    endtask

    initial begin : main
        tests = 0;
        fails = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_conflict();
        test_reset_mid_refill();
        test_rdy_stall();
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache serving the instruction fetcher's ICache query port (query_en/query_pc in, data_en/data out).
- Hits are answered from internal line storage.
- Misses refill a whole line from the memory controller through a word-granular request/response port, then answer.
- Sits between the fetcher and the memory controller; no write or flush path.

Parameters:
- INDEX_WIDTH, 4, log2 of line count (16 lines).
- LINE_WIDTH, 2, log2 of words per line (4 words = 16 bytes).
- TAG_WIDTH, 32-INDEX_WIDTH-LINE_WIDTH-2, derived tag width; not overridden.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; 0 = hold all state
- icache_query_en  in  1  fetcher request, held high until data_en is sampled
- icache_query_pc  in  32  fetch address, stable while query_en high
- icache_data_en  out  1  one-cycle response pulse
- icache_data  out  32  instruction word for the query
- mem_query_en  out  1  refill word request, held until mem_data_en
- mem_query_addr  out  32  word-aligned refill address
- mem_data_en  in  1  one-cycle memory response pulse
- mem_data  in  32  refill word

Behaviour:
- Address split: offset = pc[LINE_WIDTH+1:2]; index = pc[INDEX_WIDTH+LINE_WIDTH+1:LINE_WIDTH+2]; tag = pc[31:INDEX_WIDTH+LINE_WIDTH+2]. pc[1:0] ignored.
- Storage: per line one valid bit, one tag and 2^LINE_WIDTH words.
- Reset: all valid bits 0, state IDLE, icache_data_en=0, icache_data=0, mem_query_en=0, mem_query_addr=0, refill counter 0. Reset has priority over rdy_in.
- rdy_in=0: no register changes; outputs hold their values.
- States: IDLE, RESPOND, MISS_REQ, MISS_WAIT.
- IDLE, query_en=0: nothing happens.
- IDLE, query_en=1: latch query_pc into req_pc; compare against valid/tag at index.
  - Hit: icache_data <= word[offset], icache_data_en <= 1, go RESPOND. Data_en is visible the cycle after query_en is first sampled.
  - Miss: refill counter <= 0, go MISS_REQ.
- RESPOND: icache_data_en <= 0, go IDLE. Query_en is ignored in this cycle because the fetcher drops it on the edge it samples data_en. This guarantees exactly one pulse per query.
- MISS_REQ: mem_query_en <= 1, mem_query_addr <= {req_pc[31:LINE_WIDTH+2], counter, 2'b00}, go MISS_WAIT.
- MISS_WAIT, mem_data_en=1:
  - Write mem_data into line[index].word[counter]; mem_query_en <= 0.
  - Counter not at last word: counter+1, go MISS_REQ. mem_query_en is therefore low for at least one cycle between word requests.
  - Last word: set valid, store tag, go IDLE. The still-pending query then hits on the next IDLE cycle.
- MISS_WAIT, mem_data_en=0: hold mem_query_en and mem_query_addr.
- Refill replaces the line unconditionally (direct-mapped eviction). Valid stays 0 until the last word is written.
- mem_data_en outside MISS_WAIT is ignored.
- Reset mid-refill: aborts the refill, clears mem_query_en, leaves the line invalid.
- Hit latency: 1 cycle.
- Miss latency: 2^LINE_WIDTH memory round trips, plus 1 gap cycle per word, plus 1 cycle for the final hit.
- Counter width is LINE_WIDTH. No wrap beyond the last word; the refill always starts at word 0.

Test Plan:
- Cold miss:
  - Stimulus: reset, then query_en=1, pc=0x0000_0010; memory returns 0xA0,0xA1,0xA2,0xA3 each 2 cycles after request.
  - Response: mem_query_addr sequence 0x10,0x14,0x18,0x1C with mem_query_en low one cycle between each; then a single data_en pulse with data=0xA0.
- Hit:
  - Stimulus: after cold miss, query pc=0x0000_0018.
  - Response: data_en one cycle later, data=0xA2, no mem_query_en; data_en high exactly one cycle.
- Conflict eviction:
  - Stimulus: query 0x0000_0110 (same index 1, tag 1).
  - Response: refill 0x110..0x11C, correct data returned; a following query of 0x10 misses again and refills from 0x10.
- Reset mid-refill:
  - Stimulus: assert rst_in while in MISS_WAIT on the second word.
  - Response: next cycle mem_query_en=0, data_en=0; re-query of 0x10 performs a full 4-word refill.
- rdy_in stall:
  - Stimulus: drop rdy_in for 3 cycles during MISS_WAIT while mem_data_en pulses are withheld.
  - Response: mem_query_en/addr unchanged; refill resumes with correct addresses after rdy_in returns.
- Back-to-back queries:
  - Stimulus: fetcher re-raises query_en (pc 0x14) the cycle after RESPOND.
  - Response: that query is accepted from IDLE and answered with data=0xA1; no duplicate pulse.
